// File: rtl/orion_mem_responder_pkg.sv
// Shared types for the orion memory responder: capture register layout, FSM encoding, counter width.
// Optional build macro ORION_MEM_ERR_EN is consumed by the interface and top, not here.
package orion_mem_responder_pkg;

  localparam int unsigned MEM_ADDRW = 32;
  localparam int unsigned MEM_DATAW = 32;
  localparam int unsigned MEM_MASKW = MEM_DATAW / 8;
  localparam int unsigned MEM_LAT_W = 4;

  typedef struct packed {
    logic [MEM_ADDRW-1:0] addr;
    logic [MEM_DATAW-1:0] wdata;
    logic [MEM_MASKW-1:0] mask;
    logic                 we;
  } mem_req_t;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_RESP = 2'd2
  } mem_rsp_state_t;

endpackage

// File: rtl/orion_mem_responder_if.sv
// Core cache/memory bus between an IF/MEM master and a memory responder.
// ORION_MEM_ERR_EN adds the rsp_err response bit.
interface orion_mem_responder_if #(
  parameter int unsigned ADDRW = 32,
  parameter int unsigned DATAW = 32
);
  localparam int unsigned MASKW = DATAW / 8;

  logic [ADDRW-1:0] req_addr;
  logic             req_valid;
  logic [DATAW-1:0] req_wdata;
  logic [MASKW-1:0] req_mask;
  logic             req_we;
  logic [DATAW-1:0] rsp_rdata;
  logic             rsp_ack;
`ifdef ORION_MEM_ERR_EN
  logic             rsp_err;
`endif

  modport master (
    output req_addr, req_valid, req_wdata, req_mask, req_we,
`ifdef ORION_MEM_ERR_EN
    input  rsp_err,
`endif
    input  rsp_rdata, rsp_ack
  );

  modport slave (
    input  req_addr, req_valid, req_wdata, req_mask, req_we,
`ifdef ORION_MEM_ERR_EN
    output rsp_err,
`endif
    output rsp_rdata, rsp_ack
  );

endinterface

// File: rtl/orion_mem_responder_sram_bw.sv
// Single-port synchronous word array with per-byte write enables (BRAM style).
// The array is never reset; only the read-data register has a reset value.
module orion_sram_bw #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned DATAW = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATAW-1:0]         wdata,
  input  logic [DATAW/8-1:0]       be,
  input  logic                     rd_en,
  input  logic                     rd_clr,
  output logic [DATAW-1:0]         rdata
);
  localparam int unsigned MASKW = DATAW / 8;

  logic [DATAW-1:0] mem_q [DEPTH];
  logic [DATAW-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(MASKW); i++) begin
      if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Read register holds its word until the next read; rd_clr forces a zero read.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) rdata_d = rd_clr ? '0 : mem_q[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/orion_mem_responder.sv
// Memory responder: captures one request, waits LATENCY cycles, commits to SRAM and pulses ack.
// Build option ORION_MEM_ERR_EN: rsp_err for out-of-range or word-crossing misaligned accesses.
module orion_mem_responder
  import orion_mem_responder_pkg::*;
#(
  parameter int unsigned ADDRW   = MEM_ADDRW,
  parameter int unsigned DATAW   = MEM_DATAW,
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned LATENCY = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  orion_mem_responder_if.slave bus
);
  localparam int unsigned MASKW = DATAW / 8;
  localparam int unsigned OFFW  = $clog2(MASKW);
  localparam int unsigned IDXW  = $clog2(DEPTH);
  localparam logic [MEM_LAT_W-1:0] LAT_M1 =
    MEM_LAT_W'((LATENCY == 0) ? 0 : LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'(MEM_IDLE);
  localparam logic [1:0] S_WAIT = 2'(MEM_WAIT);
  localparam logic [1:0] S_RESP = 2'(MEM_RESP);

  logic [1:0]           state_q, state_d;
  logic [MEM_LAT_W-1:0] cnt_q, cnt_d;
  mem_req_t             req_q, req_d;
  logic                 ack_q, ack_d;
  mem_req_t             in_req, cur;
  logic                 fire, err_c;
  logic [MASKW-1:0]     wr_be;

  // With zero latency the commit happens on the capture edge, so use the bus directly.
  always_comb begin
    in_req.addr  = MEM_ADDRW'(bus.req_addr);
    in_req.wdata = MEM_DATAW'(bus.req_wdata);
    in_req.mask  = MEM_MASKW'(bus.req_mask);
    in_req.we    = bus.req_we;
    cur          = (state_q == S_IDLE) ? in_req : req_q;
  end

  always_comb begin
    err_c = |(cur.addr >> (OFFW + IDXW));
`ifdef ORION_MEM_ERR_EN
    // Misaligned: the mask shifted up by the byte offset spills past the word.
    err_c = err_c |
      (|(((2*MASKW)'(cur.mask) << cur.addr[OFFW-1:0]) >> MASKW));
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    fire    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          req_d = in_req;
          if (LATENCY == 0) begin
            state_d = S_RESP;
            fire    = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ack_d = fire;
    wr_be = (fire && cur.we && !err_c) ? MASKW'(cur.mask) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
    end
  end

`ifdef ORION_MEM_ERR_EN
  logic err_q, err_d;
  assign err_d = fire & err_c;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign bus.rsp_err = err_q;
`endif

  orion_sram_bw #(.DEPTH(DEPTH), .DATAW(DATAW)) u_sram (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr   (cur.addr[OFFW +: IDXW]),
    .wdata  (DATAW'(cur.wdata)),
    .be     (wr_be),
    .rd_en  (fire & ~cur.we),
    .rd_clr (err_c),
    .rdata  (bus.rsp_rdata)
  );

  assign bus.rsp_ack = ack_q;

endmodule

// File: tb/tb_orion_mem_responder.sv
// Randomised self-checking bench: LATENCY=2 and LATENCY=0 responders against a word-array model.
// Build with ORION_MEM_ERR_EN defined to also check rsp_err.
module tb_orion_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  orion_mem_responder_if #(.ADDRW(32), .DATAW(32)) if_a ();
  orion_mem_responder_if #(.ADDRW(32), .DATAW(32)) if_b ();

  orion_mem_responder #(.DEPTH(4096), .LATENCY(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  orion_mem_responder #(.DEPTH(4096), .LATENCY(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  int n_tests = 0;
  int n_fail  = 0;
  int lats [2] = '{2, 0};
  logic [31:0] mdl [2][32];
  logic [31:0] last_rd [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [31:0] a, input logic we,
                       input logic [31:0] wd, input logic [3:0] m);
    if (sel == 0) begin
      if_a.req_valid = v; if_a.req_addr = a; if_a.req_we = we; if_a.req_wdata = wd; if_a.req_mask = m;
    end else begin
      if_b.req_valid = v; if_b.req_addr = a; if_b.req_we = we; if_b.req_wdata = wd; if_b.req_mask = m;
    end
  endtask

  function automatic logic ack_of(input int sel);
    return (sel == 0) ? if_a.rsp_ack : if_b.rsp_ack;
  endfunction
  function automatic logic [31:0] rd_of(input int sel);
    return (sel == 0) ? if_a.rsp_rdata : if_b.rsp_rdata;
  endfunction
  function automatic logic err_of(input int sel);
`ifdef ORION_MEM_ERR_EN
    return (sel == 0) ? if_a.rsp_err : if_b.rsp_err;
`else
    return 1'b0;
`endif
  endfunction

  // Out of range above 16 KiB; with the error option, a mask moved up by the offset must fit in 4 bytes.
  function automatic logic exp_err(input logic [31:0] a, input logic [3:0] m);
    int span;
    span = int'(m) * (1 << a[1:0]);
    return (a >= 32'h4000) || (span > 15 && a[1:0] != 2'd0 && `ifdef ORION_MEM_ERR_EN 1'b1 `else 1'b0 `endif);
  endfunction

  task automatic access(input int sel, input logic [31:0] a, input logic we,
                        input logic [31:0] wd, input logic [3:0] m, output logic [31:0] rd);
    int lat;
    logic got, e, ex;
    logic [31:0] expd;
    ex = exp_err(a, m);
    @(negedge clk);
    drive(sel, 1'b1, a, we, wd, m);
    lat = -1; got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(posedge clk); #1;
      if (ack_of(sel)) begin got = 1'b1; lat = c; end
    end
    rd = rd_of(sel); e = err_of(sel);
    check("ack_latency", 64'(lat), 64'(lats[sel] + 1));
    @(negedge clk);
    drive(sel, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    @(posedge clk); #1;
    check("ack_single_pulse", 64'(ack_of(sel)), 64'd0);
    if (we) begin
      check("wr_rdata_hold", 64'(rd), 64'(last_rd[sel]));
      if (!ex)
        for (int b = 0; b < 4; b++) if (m[b]) mdl[sel][a[6:2]][8*b +: 8] = wd[8*b +: 8];
    end else begin
      expd = ex ? 32'h0 : mdl[sel][a[6:2]];
      check("rd_data", 64'(rd), 64'(expd));
      last_rd[sel] = expd;
    end
`ifdef ORION_MEM_ERR_EN
    check("rsp_err", 64'(e), 64'(ex));
`else
    check("err_model_base", 64'(e), 64'(ex & (a >= 32'h4000) & 1'b0));
`endif
  endtask

  logic [31:0] r;
  int acks, first_cyc, gap, consec;
  logic prev_ack;
  logic [31:0] rds [2];

  initial begin
    drive(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack_a", 64'(if_a.rsp_ack), 64'd0);
    check("rst_rdata_a", 64'(if_a.rsp_rdata), 64'd0);
    check("rst_ack_b", 64'(if_b.rsp_ack), 64'd0);
    check("rst_rdata_b", 64'(if_b.rsp_rdata), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Give every modelled word a known value.
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 32; i++) access(s, 32'(i * 4), 1'b1, $urandom, 4'hF, r);

    // Directed: full write/read, partial byte write, mask-0 write.
    access(0, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, r);
    access(0, 32'h10, 1'b0, 32'h0, 4'h0, r);
    check("rd_deadbeef", 64'(r), 64'h0000_0000_DEAD_BEEF);
    access(0, 32'h20, 1'b1, 32'h11223344, 4'hF, r);
    access(0, 32'h20, 1'b1, 32'h0000AA00, 4'h2, r);
    access(0, 32'h20, 1'b0, 32'h0, 4'h0, r);
    check("rd_partial", 64'(r), 64'h1122AA44);
    access(0, 32'h10, 1'b1, 32'h12345678, 4'h0, r);
    access(0, 32'h10, 1'b0, 32'h0, 4'hF, r);
    check("rd_mask0_noop", 64'(r), 64'hDEADBEEF);

    // rdata holds across an unrelated write and afterwards.
    access(0, 32'h24, 1'b1, 32'hCAFEF00D, 4'hF, r);
    check("rdata_hold_after", 64'(if_a.rsp_rdata), 64'hDEADBEEF);

    // Out of range: acked, write suppressed, read returns 0.
    access(0, 32'h0001_0000, 1'b1, 32'h55, 4'hF, r);
    access(0, 32'h0001_0000, 1'b0, 32'h0, 4'hF, r);
    check("oor_rd_zero", 64'(r), 64'd0);
    access(0, 32'h0, 1'b0, 32'h0, 4'hF, r);
    access(0, 32'h11, 1'b0, 32'h0, 4'hF, r);

    // Reset while a write to 0x40 sits in WAIT: aborted, no ack, rdata cleared.
    @(negedge clk);
    drive(0, 1'b1, 32'h40, 1'b1, 32'hA5A5A5A5, 4'hF);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    #1;
    check("rst_wait_rdata", 64'(if_a.rsp_rdata), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_wait_noack", 64'(if_a.rsp_ack), 64'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    access(0, 32'h40, 1'b0, 32'h0, 4'hF, r);

    // LATENCY=0 with valid held across two reads: acks two cycles apart, no duplicate.
    acks = 0; first_cyc = -1; gap = -1; consec = 0; prev_ack = 1'b0;
    rds[0] = 32'h0; rds[1] = 32'h0;
    @(negedge clk);
    drive(1, 1'b1, 32'h8, 1'b0, 32'h0, 4'hF);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (if_b.rsp_ack) begin
        if (prev_ack) consec++;
        if (acks < 2) rds[acks] = if_b.rsp_rdata;
        if (acks == 0) first_cyc = c; else if (acks == 1) gap = c - first_cyc;
        acks++;
      end
      prev_ack = if_b.rsp_ack;
      @(negedge clk);
      if (if_b.rsp_ack && acks == 1) drive(1, 1'b1, 32'hC, 1'b0, 32'h0, 4'hF);
      else if (if_b.rsp_ack && acks == 2) drive(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    end
    check("b2b_ack_count", 64'(acks), 64'd2);
    check("b2b_first_ack", 64'(first_cyc), 64'd1);
    check("b2b_ack_gap", 64'(gap), 64'd2);
    check("b2b_no_consec", 64'(consec), 64'd0);
    check("b2b_rd0", 64'(rds[0]), 64'(mdl[1][2]));
    check("b2b_rd1", 64'(rds[1]), 64'(mdl[1][3]));
    last_rd[1] = mdl[1][3];

    // Randomised mix over both responders.
    for (int t = 0; t < 160; t++) begin
      logic [31:0] a;
      a = {25'h0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(14, 31));
      access(int'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), $urandom,
             4'($urandom_range(0, 15)), r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
